rom_varredor: RTL and testbench
===============================

Name: rom_varredor

Overview:
- Read-side master for the 512x8 synchronous ROM (`CLK`, `Endereco[8:0]`, `Dados[7:0]`; ROM data is registered and valid the cycle after the address).
- On `Iniciar`, streams addresses from 0 upward, one per cycle, and consumes ROM words with one-cycle latency.
- Stops at the first sentinel word (0xFF) or at the end of the ROM.
- Reports minimum, maximum, sum and element count of the words preceding the sentinel, for the downstream sorting/display logic.

Parameters:
- LARG_DADO, 8, ROM word width.
- LARG_END, 9, ROM address width.
- PROFUNDIDADE, 512, number of ROM words (2^LARG_END).
- SENTINELA, 8'hFF, end-of-list marker; never counted as data.

Ports:
- CLK  in  1  system clock; all state on rising edge.
- Reset_n  in  1  synchronous reset, active-low.
- Iniciar  in  1  start request, sampled only in OCIOSO.
- Dados  in  LARG_DADO  ROM registered output (word at the address driven in the previous cycle).
- Endereco  out  LARG_END  ROM address.
- Ocupado  out  1  high while a scan is in progress.
- Pronto  out  1  one-cycle pulse when results are final.
- Minimo  out  LARG_DADO  minimum of counted words.
- Maximo  out  LARG_DADO  maximum of counted words.
- Soma  out  17  sum of counted words (512*254 fits).
- Contagem  out  10  number of counted words, 0..512.

Behaviour:
- **Reset.** Reset_n=0 at a rising edge gives state OCIOSO and the following output values:
  - Endereco=0, Ocupado=0, Pronto=0.
  - Minimo=0xFF, Maximo=0x00, Soma=0, Contagem=0.
  - Internal valid flag vld=0.
  - Reset mid-scan aborts the scan immediately; no Pronto is produced.
- **States.** OCIOSO, LENDO, FIM.
- **OCIOSO.**
  - Iniciar=1 at edge E0 moves to LENDO.
  - At E0: Endereco=0, Ocupado=1, vld=0; Minimo/Maximo/Soma/Contagem reload their reset values.
  - Iniciar is ignored in LENDO and FIM.
- **LENDO, address side.**
  - Each edge: if Endereco<PROFUNDIDADE-1, Endereco increments.
  - At 511 it holds (no wrap); a last-address flag is set.
  - vld is set at the edge after each issued address, so vld=1 means Dados is the word for the previously issued address.
- **LENDO, consume side** (each edge with vld=1):
  - If Dados==SENTINELA, go to FIM; the word is not counted.
  - Otherwise: Minimo=min(Minimo,Dados), Maximo=max(Maximo,Dados), Soma+=Dados (zero-extended), Contagem+=1.
  - If that word was address 511, go to FIM after accumulating it.
- **Timing.**
  - The word at address i is consumed at edge E0+2+i.
  - A sentinel at index N gives FIM at edge E0+2+N.
  - No sentinel gives FIM at E0+513 with Contagem=512.
- **Overrun.** Addresses issued beyond the sentinel (at most 2) are harmless; ROM reads have no side effects.
- **FIM.**
  - Lasts exactly one cycle: Pronto=1, Ocupado=0.
  - Next edge returns to OCIOSO with Pronto=0.
- **Result holding.** Results are held unchanged until the next accepted Iniciar or reset.
- **Empty list.** Sentinel at address 0 gives Contagem=0, Soma=0, Minimo=0xFF, Maximo=0x00, and Pronto at E0+2.
- **Iniciar held high.** A new scan starts in the cycle after FIM returns to OCIOSO, i.e. back-to-back scans separated by one OCIOSO cycle.
- **Registers.** All outputs are registered; no combinational path from Dados or Iniciar to any output.

Test Plan:
- **Default ROM contents** (10,2,7,12,25,31,47,3, then 0xFF); pulse Iniciar at E0 → Pronto high exactly in the cycle after E10. Required results: Minimo=2, Maximo=47, Soma=137, Contagem=8, Ocupado high E0..E10.
- **Sentinel at address 0** → Pronto after E2. Required results: Contagem=0, Soma=0, Minimo=0xFF, Maximo=0x00.
- **ROM filled with 0xFE at all 512 words** → Endereco stops at 511 without wrapping, Pronto after E513. Required results: Contagem=512, Soma=130048, Minimo=Maximo=0xFE.
- **Reset mid-scan:** Reset_n=0 for one edge at E5 → all outputs return to their reset values and no Pronto occurs. A later Iniciar reproduces the results of the default-contents scenario.
- **Iniciar asserted during LENDO** → ignored; single Pronto, results unchanged. With Iniciar held high continuously → second scan starts one cycle after Pronto and gives identical results.
- **Contents 0x00, 0xFE, 0x80, 0xFF** → Minimo=0x00, Maximo=0xFE, Soma=382, Contagem=3.

Source files
------------

// File: rtl/rom_varredor_if.sv
// Connection between the ROM scanner and its ROM and consumers: start request, ROM
// address/data and the scan results.
interface rom_varredor_if #(
   parameter int unsigned LARG_DADO = 8,
   parameter int unsigned LARG_END  = 9
);
   logic                 Iniciar;
   logic [LARG_DADO-1:0] Dados;
   logic [LARG_END-1:0]  Endereco;
   logic                 Ocupado;
   logic                 Pronto;
   logic [LARG_DADO-1:0] Minimo;
   logic [LARG_DADO-1:0] Maximo;
   logic [16:0]          Soma;
   logic [9:0]           Contagem;

   // Scanner side
   modport master (
      input  Iniciar, Dados,
      output Endereco, Ocupado, Pronto, Minimo, Maximo, Soma, Contagem
   );

   // ROM plus result consumer side
   modport slave (
      output Iniciar, Dados,
      input  Endereco, Ocupado, Pronto, Minimo, Maximo, Soma, Contagem
   );
endinterface

// File: rtl/rom_varredor.sv
// Sequential ROM scanner: reads a 512x8 registered-output ROM from address 0 upward until
// it sees the sentinel word or reaches the last address. It reports the minimum, maximum,
// sum and count of the words that come before the sentinel.
module rom_varredor #(
   parameter int unsigned          LARG_DADO    = 8,
   parameter int unsigned          LARG_END     = 9,
   parameter int unsigned          PROFUNDIDADE = 512,
   parameter logic [LARG_DADO-1:0] SENTINELA    = 8'hFF
) (
   input logic            CLK,
   input logic            Reset_n,
   rom_varredor_if.master bus
);

   localparam logic [LARG_END-1:0] ULTIMO_END = LARG_END'(PROFUNDIDADE - 1);

   typedef enum logic [1:0] {OCIOSO, LENDO, FIM} estado_t;

   estado_t              estado, estado_prox;
   logic [LARG_END-1:0]  end_r, end_prox;
   logic                 vld_r, vld_prox;        // Dados holds the word for the last issued address
   logic                 ultimo_r, ultimo_prox;  // the word on Dados comes from the last address
   logic                 ocupado_r, ocupado_prox;
   logic                 pronto_r, pronto_prox;
   logic [LARG_DADO-1:0] min_r, min_prox;
   logic [LARG_DADO-1:0] max_r, max_prox;
   logic [16:0]          soma_r, soma_prox;
   logic [9:0]           cont_r, cont_prox;

   // Next state: the address side runs one cycle ahead of the consume side
   always_comb begin
      estado_prox = estado;
      end_prox    = end_r;
      vld_prox    = vld_r;
      ultimo_prox = ultimo_r;
      min_prox    = min_r;
      max_prox    = max_r;
      soma_prox   = soma_r;
      cont_prox   = cont_r;

      unique case (estado)
         OCIOSO: begin
            if (bus.Iniciar) begin
               estado_prox = LENDO;
               end_prox    = '0;
               vld_prox    = 1'b0;
               ultimo_prox = 1'b0;
               min_prox    = '1;
               max_prox    = '0;
               soma_prox   = '0;
               cont_prox   = '0;
            end
         end
         LENDO: begin
            if (end_r < ULTIMO_END) begin
               end_prox = end_r + 1'b1;
            end
            // ROM captures the last address at this edge, so its word appears next cycle
            if (end_r == ULTIMO_END) begin
               ultimo_prox = 1'b1;
            end
            vld_prox = 1'b1;
            if (vld_r) begin
               if (bus.Dados == SENTINELA) begin
                  estado_prox = FIM;
               end else begin
                  if (bus.Dados < min_r) min_prox = bus.Dados;
                  if (bus.Dados > max_r) max_prox = bus.Dados;
                  soma_prox = soma_r + 17'(bus.Dados);
                  cont_prox = cont_r + 10'd1;
                  if (ultimo_r) estado_prox = FIM;
               end
            end
         end
         FIM: begin
            estado_prox = OCIOSO;
            vld_prox    = 1'b0;
         end
         default: estado_prox = OCIOSO;
      endcase

      ocupado_prox = (estado_prox == LENDO);
      pronto_prox  = (estado_prox == FIM);
   end

   // State and output registers with synchronous reset
   always_ff @(posedge CLK) begin
      if (!Reset_n) begin
         estado    <= OCIOSO;
         end_r     <= '0;
         vld_r     <= 1'b0;
         ultimo_r  <= 1'b0;
         ocupado_r <= 1'b0;
         pronto_r  <= 1'b0;
         min_r     <= '1;
         max_r     <= '0;
         soma_r    <= '0;
         cont_r    <= '0;
      end else begin
         estado    <= estado_prox;
         end_r     <= end_prox;
         vld_r     <= vld_prox;
         ultimo_r  <= ultimo_prox;
         ocupado_r <= ocupado_prox;
         pronto_r  <= pronto_prox;
         min_r     <= min_prox;
         max_r     <= max_prox;
         soma_r    <= soma_prox;
         cont_r    <= cont_prox;
      end
   end

   assign bus.Endereco = end_r;
   assign bus.Ocupado  = ocupado_r;
   assign bus.Pronto   = pronto_r;
   assign bus.Minimo   = min_r;
   assign bus.Maximo   = max_r;
   assign bus.Soma     = soma_r;
   assign bus.Contagem = cont_r;

endmodule

// File: tb/tb_rom_varredor.sv
// Bench for rom_varredor: a behavioural 512x8 registered ROM and a table of ROM images
// with hand-computed results, plus sequences for reset mid-scan and Iniciar held high.
module tb_rom_varredor;

   logic CLK = 1'b0;
   logic Reset_n;

   rom_varredor_if bus ();

   rom_varredor dut (
      .CLK     (CLK),
      .Reset_n (Reset_n),
      .bus     (bus)
   );

   always #5 CLK = ~CLK;

   // ROM model: the word is registered, so it is valid the cycle after its address
   logic [7:0] rom [512];
   always @(posedge CLK) bus.Dados <= rom[bus.Endereco];

   typedef struct packed {
      logic [8:0][7:0] palavras;  // word 0 is the rightmost byte
      logic [3:0]      n;         // number of leading words taken from palavras
      logic [7:0]      preench;   // value of every other ROM word
      logic [7:0]      e_min;
      logic [7:0]      e_max;
      logic [16:0]     e_soma;
      logic [9:0]      e_cont;
      logic [9:0]      e_lat;     // edges from E0 to the edge that raises Pronto
   } vec_t;

   vec_t vetores [5];

   int n_assert = 0;
   int n_fail   = 0;

   task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
      n_assert++;
      if (atual !== esperado) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nome, atual, esperado);
      end
   endtask

   task automatic carrega(input vec_t v);
      for (int i = 0; i < 512; i++) rom[i] = v.preench;
      for (int i = 0; i < 9; i++) if (i < int'(v.n)) rom[i] = v.palavras[i];
   endtask

   task automatic check_reset(input string tag);
      check({tag, " Endereco"}, 32'(bus.Endereco), 32'd0);
      check({tag, " Ocupado"},  32'(bus.Ocupado),  32'd0);
      check({tag, " Pronto"},   32'(bus.Pronto),   32'd0);
      check({tag, " Minimo"},   32'(bus.Minimo),   32'hFF);
      check({tag, " Maximo"},   32'(bus.Maximo),   32'h00);
      check({tag, " Soma"},     32'(bus.Soma),     32'd0);
      check({tag, " Contagem"}, 32'(bus.Contagem), 32'd0);
   endtask

   task automatic check_result(input string tag, input vec_t v);
      check({tag, " Minimo"},   32'(bus.Minimo),   32'(v.e_min));
      check({tag, " Maximo"},   32'(bus.Maximo),   32'(v.e_max));
      check({tag, " Soma"},     32'(bus.Soma),     32'(v.e_soma));
      check({tag, " Contagem"}, 32'(bus.Contagem), 32'(v.e_cont));
   endtask

   // Starts one scan at the next edge (E0) and follows it to Pronto. modo=1 also pulses
   // Iniciar while the scan is running, which must be ignored.
   task automatic run_scan(input vec_t v, input int modo, input string tag);
      int         lat;
      bit         ocup_ok;
      bit         wrap;
      bit         extra;
      logic [8:0] end_ant;
      @(negedge CLK) bus.Iniciar = 1'b1;
      @(posedge CLK);
      @(negedge CLK) bus.Iniciar = 1'b0;
      check({tag, " Ocupado after E0"}, 32'(bus.Ocupado), 32'd1);
      lat     = 0;
      ocup_ok = 1'b1;
      wrap    = 1'b0;
      end_ant = bus.Endereco;
      for (int k = 1; k <= 600 && lat == 0; k++) begin
         if (modo == 1 && k == 3) bus.Iniciar = 1'b1;
         if (modo == 1 && k == 5) bus.Iniciar = 1'b0;
         @(posedge CLK);
         @(negedge CLK);
         if (bus.Endereco < end_ant) wrap = 1'b1;
         end_ant = bus.Endereco;
         if (bus.Pronto) lat = k;
         else if (!bus.Ocupado) ocup_ok = 1'b0;
      end
      bus.Iniciar = 1'b0;
      check({tag, " Pronto latency"},    32'(lat),         32'(v.e_lat));
      check({tag, " Ocupado at Pronto"}, 32'(bus.Ocupado), 32'd0);
      check({tag, " Ocupado during scan"}, 32'(ocup_ok),   32'd1);
      check({tag, " Endereco no wrap"},  32'(wrap),        32'd0);
      check_result(tag, v);
      @(posedge CLK);
      @(negedge CLK);
      check({tag, " Pronto one cycle"}, 32'(bus.Pronto), 32'd0);
      extra = 1'b0;
      for (int k = 0; k < 15; k++) begin
         @(posedge CLK);
         @(negedge CLK);
         if (bus.Pronto || bus.Ocupado) extra = 1'b0 | 1'b1;
      end
      check({tag, " idle after scan"}, 32'(extra), 32'd0);
      check_result({tag, " held"}, v);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      int  p1, p2, np;
      bit  viu_pronto;

      vetores[0] = '{palavras: {8'hFF, 8'd3, 8'd47, 8'd31, 8'd25, 8'd12, 8'd7, 8'd2, 8'd10},
                     n: 4'd9, preench: 8'h00, e_min: 8'd2, e_max: 8'd47,
                     e_soma: 17'd137, e_cont: 10'd8, e_lat: 10'd10};
      vetores[1] = '{palavras: {64'h0, 8'hFF}, n: 4'd1, preench: 8'h00,
                     e_min: 8'hFF, e_max: 8'h00, e_soma: 17'd0, e_cont: 10'd0, e_lat: 10'd2};
      vetores[2] = '{palavras: {40'h0, 8'hFF, 8'h80, 8'hFE, 8'h00}, n: 4'd4, preench: 8'h00,
                     e_min: 8'h00, e_max: 8'hFE, e_soma: 17'd382, e_cont: 10'd3, e_lat: 10'd5};
      vetores[3] = '{palavras: {56'h0, 8'hFF, 8'h05}, n: 4'd2, preench: 8'h33,
                     e_min: 8'h05, e_max: 8'h05, e_soma: 17'd5, e_cont: 10'd1, e_lat: 10'd3};
      vetores[4] = '{palavras: 72'h0, n: 4'd0, preench: 8'hFE,
                     e_min: 8'hFE, e_max: 8'hFE, e_soma: 17'd130048, e_cont: 10'd512,
                     e_lat: 10'd513};

      Reset_n     = 1'b0;
      bus.Iniciar = 1'b0;
      carrega(vetores[0]);
      repeat (2) @(posedge CLK);
      @(negedge CLK) Reset_n = 1'b1;
      check_reset("reset");

      for (int i = 0; i < 5; i++) begin
         carrega(vetores[i]);
         run_scan(vetores[i], 0, $sformatf("vec%0d", i));
      end
      check("vec4 Endereco stops at 511", 32'(bus.Endereco), 32'd511);

      // Reset for one edge at E5 aborts the scan without Pronto
      carrega(vetores[0]);
      @(negedge CLK) bus.Iniciar = 1'b1;
      @(posedge CLK);
      @(negedge CLK) bus.Iniciar = 1'b0;
      repeat (4) @(posedge CLK);
      @(negedge CLK) Reset_n = 1'b0;
      @(posedge CLK);
      @(negedge CLK) Reset_n = 1'b1;
      check_reset("mid-scan reset");
      viu_pronto = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(posedge CLK);
         @(negedge CLK);
         if (bus.Pronto) viu_pronto = 1'b1;
      end
      check("no Pronto after reset", 32'(viu_pronto), 32'd0);
      run_scan(vetores[0], 0, "after reset");

      // Iniciar pulsed during LENDO is ignored
      run_scan(vetores[0], 1, "Iniciar in LENDO");

      // Iniciar held high: back-to-back scans separated by one OCIOSO cycle
      np = 0;
      p1 = 0;
      p2 = 0;
      @(negedge CLK) bus.Iniciar = 1'b1;
      @(posedge CLK);
      for (int k = 1; k <= 40; k++) begin
         @(posedge CLK);
         @(negedge CLK);
         if (bus.Pronto) begin
            np++;
            if (np == 1) p1 = k;
            if (np == 2) begin
               p2 = k;
               check_result("held second scan", vetores[0]);
               bus.Iniciar = 1'b0;
            end
         end
         if (k == 11) check("held Ocupado in OCIOSO gap", 32'(bus.Ocupado), 32'd0);
         if (k == 12) check("held Ocupado restart", 32'(bus.Ocupado), 32'd1);
      end
      bus.Iniciar = 1'b0;
      check("held Pronto count", 32'(np), 32'd2);
      check("held first Pronto", 32'(p1), 32'd10);
      check("held second Pronto", 32'(p2), 32'd22);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
